// File: rtl/act_lut_fifo_if.sv
// act_lut_fifo_if -- bundle of every non-clock signal of act_lut_fifo.
//   PU side    : mode, din, enq -> pu_dout, pu_dout_valid
//   FIFO side  : deq, dout_ack -> dout, dout_valid, full, count, sat_cnt
//   Config bus : ram_din, ram_reg_adr, ram_mem_adr, ram_we (LUT loading)
// Modports: master = driver (PU / consumer / config host), slave = act_lut_fifo.
interface act_lut_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 26,
    parameter int FIFO_AW    = 4,
    parameter int RAMDATA_W  = 21,
    parameter int MEMSEL_W   = 6,
    parameter int REGSEL_W   = 14
);
    logic [2:0]            mode;
    logic [ACC_WIDTH-1:0]  din;
    logic                  enq;
    logic                  deq;
    logic                  dout_ack;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [DATA_WIDTH-1:0] pu_dout;
    logic                  pu_dout_valid;
    logic                  full;
    logic [FIFO_AW:0]      count;
    logic [15:0]           sat_cnt;
    logic [RAMDATA_W-1:0]  ram_din;
    logic [REGSEL_W-1:0]   ram_reg_adr;
    logic [MEMSEL_W-1:0]   ram_mem_adr;
    logic                  ram_we;

    modport master (
        output mode, din, enq, deq, dout_ack, ram_din, ram_reg_adr, ram_mem_adr, ram_we,
        input  dout, dout_valid, pu_dout, pu_dout_valid, full, count, sat_cnt
    );

    modport slave (
        input  mode, din, enq, deq, dout_ack, ram_din, ram_reg_adr, ram_mem_adr, ram_we,
        output dout, dout_valid, pu_dout, pu_dout_valid, full, count, sat_cnt
    );
endinterface

// File: rtl/act_lut_fifo.sv
// act_lut_fifo -- activation unit: signed accumulator -> LUT (sigmoid etc.) or
// saturating ReLU, 3-stage pipeline. SIG1 results return on pu_dout; SIG2/RELU
// results are queued in a 2^FIFO_AW FIFO and drained via deq/dout_ack.
// Ports:
//   CLK  clock
//   RST  synchronous active-high reset (LUT contents are kept)
//   bus  act_lut_fifo_if.slave -- PU input, FIFO output handshake, config bus
// Optional: define ACT_SAT_CNT_EN to build the saturation counter on sat_cnt;
// otherwise sat_cnt is tied to zero.
module act_lut_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 26,
    parameter int FRAC_SHIFT = 8,
    parameter int LUT_AW     = 8,
    parameter int FIFO_AW    = 4,
    parameter int RAMDATA_W  = 21,
    parameter int MEMSEL_W   = 6,
    parameter int REGSEL_W   = 14,
    parameter logic [MEMSEL_W-1:0] LUT_RAM_ADR = 6'h02
) (
    input logic CLK,
    input logic RST,
    act_lut_fifo_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_SIG1 = 3'b010,
        MODE_SIG2 = 3'b011,
        MODE_RELU = 3'b100
    } mode_e;

    localparam int LUT_HALF = 1 << (LUT_AW - 1);
    localparam logic signed [ACC_WIDTH-1:0] LUT_LO  = ACC_WIDTH'(-LUT_HALF);
    localparam logic signed [ACC_WIDTH-1:0] LUT_HI  = ACC_WIDTH'(LUT_HALF - 1);
    localparam logic signed [ACC_WIDTH-1:0] RELU_HI = ACC_WIDTH'((1 << DATA_WIDTH) - 1);
    localparam logic [LUT_AW-1:0] IDX_MSB = {1'b1, {(LUT_AW-1){1'b0}}};
    localparam logic [FIFO_AW+1:0] DEPTH  = (FIFO_AW+2)'(1 << FIFO_AW);

    logic [DATA_WIDTH-1:0] lut  [2**LUT_AW];
    logic [DATA_WIDTH-1:0] fmem [2**FIFO_AW];

    // pipeline state
    logic                        v0_pu, v0_fifo, relu0;
    logic signed [ACC_WIDTH-1:0] d0;
    logic                        v1_pu, v1_fifo, relu1_sel;
    logic [LUT_AW-1:0]           idx1;
    logic [DATA_WIDTH-1:0]       relu1;
    logic                        v2_pu, v2_fifo;
    logic [DATA_WIDTH-1:0]       res2;

    // FIFO / output state
    logic [FIFO_AW-1:0]    wptr, rptr;
    logic [FIFO_AW:0]      count_q;
    logic [DATA_WIDTH-1:0] dout_q, pu_dout_q;
    logic                  dout_valid_q, pu_dout_valid_q;

    logic                        acc_pu, acc_fifo, full, load;
    logic [FIFO_AW+1:0]          credit;
    logic signed [ACC_WIDTH-1:0] x;
    logic [LUT_AW-1:0]           idx_n;
    logic [DATA_WIDTH-1:0]       relu_n;

    // Words still in S0..S2 already own a FIFO slot, so full counts them.
    assign credit = (FIFO_AW+2)'(count_q) + (FIFO_AW+2)'(v0_fifo)
                  + (FIFO_AW+2)'(v1_fifo) + (FIFO_AW+2)'(v2_fifo);
    assign full   = credit >= DEPTH;

    assign acc_pu   = bus.enq && (bus.mode == MODE_SIG1);
    assign acc_fifo = bus.enq && !full
                      && ((bus.mode == MODE_SIG2) || (bus.mode == MODE_RELU));
    assign load     = bus.deq && (count_q != '0) && (!dout_valid_q || bus.dout_ack);

    // S1 combinational index/clamp from the S0 capture
    always_comb begin
        x      = d0 >>> FRAC_SHIFT;
        idx_n  = x[LUT_AW-1:0] ^ IDX_MSB;   // offset binary
        if (x < LUT_LO)      idx_n = '0;
        else if (x > LUT_HI) idx_n = '1;
        relu_n = x[DATA_WIDTH-1:0];
        if (x < 0)            relu_n = '0;
        else if (x > RELU_HI) relu_n = '1;
    end

    // datapath registers without reset; validity is carried by the v* flags
    always_ff @(posedge CLK) begin
        d0        <= $signed(bus.din);
        relu0     <= (bus.mode == MODE_RELU);
        idx1      <= idx_n;
        relu1     <= relu_n;
        relu1_sel <= relu0;
        res2      <= relu1_sel ? relu1 : lut[idx1];
        if (v2_fifo) fmem[wptr] <= res2;
    end

    always_ff @(posedge CLK) begin
        if (bus.ram_we && (bus.ram_mem_adr == LUT_RAM_ADR))
            lut[bus.ram_reg_adr[LUT_AW-1:0]] <= bus.ram_din[DATA_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v0_pu           <= 1'b0;
            v0_fifo         <= 1'b0;
            v1_pu           <= 1'b0;
            v1_fifo         <= 1'b0;
            v2_pu           <= 1'b0;
            v2_fifo         <= 1'b0;
            wptr            <= '0;
            rptr            <= '0;
            count_q         <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            pu_dout_q       <= '0;
            pu_dout_valid_q <= 1'b0;
        end else begin
            v0_pu   <= acc_pu;
            v0_fifo <= acc_fifo;
            v1_pu   <= v0_pu;
            v1_fifo <= v0_fifo;
            v2_pu   <= v1_pu;
            v2_fifo <= v1_fifo;

            pu_dout_valid_q <= v2_pu;
            if (v2_pu) pu_dout_q <= res2;

            if (v2_fifo) wptr <= wptr + 1'b1;
            if (load) begin
                rptr         <= rptr + 1'b1;
                dout_q       <= fmem[rptr];
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ack) begin
                dout_valid_q <= 1'b0;
            end

            case ({v2_fifo, load})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ACT_SAT_CNT_EN
    logic [15:0] sat_q;
    logic        sat0;

    // saturation judged on the S0 word, counted one edge after acceptance
    assign sat0 = relu0 ? (x > RELU_HI) : ((x < LUT_LO) || (x > LUT_HI));

    always_ff @(posedge CLK) begin
        if (RST)
            sat_q <= '0;
        else if ((v0_pu || v0_fifo) && sat0 && (sat_q != '1))
            sat_q <= sat_q + 1'b1;
    end
    assign bus.sat_cnt = sat_q;
`else
    assign bus.sat_cnt = '0;
`endif

    assign bus.full          = full;
    assign bus.count         = count_q;
    assign bus.dout          = dout_q;
    assign bus.dout_valid    = dout_valid_q;
    assign bus.pu_dout       = pu_dout_q;
    assign bus.pu_dout_valid = pu_dout_valid_q;
endmodule

// File: tb/tb_act_lut_fifo.sv
// tb_act_lut_fifo -- directed self-checking bench for act_lut_fifo.
// Ports exercised: CLK/RST plus every signal of act_lut_fifo_if.
// Honours ACT_SAT_CNT_EN for the expected sat_cnt values.
module tb_act_lut_fifo;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef ACT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    always #5 CLK = ~CLK;

    act_lut_fifo_if #(.DATA_WIDTH(8), .ACC_WIDTH(26), .FIFO_AW(4),
                      .RAMDATA_W(21), .MEMSEL_W(6), .REGSEL_W(14)) bus ();

    act_lut_fifo #(.DATA_WIDTH(8), .ACC_WIDTH(26), .FRAC_SHIFT(8), .LUT_AW(8),
                   .FIFO_AW(4), .RAMDATA_W(21), .MEMSEL_W(6), .REGSEL_W(14),
                   .LUT_RAM_ADR(6'h02)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.mode = 3'b000; bus.din = '0; bus.enq = 0; bus.deq = 0; bus.dout_ack = 0;
        bus.ram_din = '0; bus.ram_reg_adr = '0; bus.ram_mem_adr = '0; bus.ram_we = 0;
        step(); step();
        RST = 0;
        check("rst_dout", bus.dout, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_pu_dout", bus.pu_dout, 0);
        check("rst_pu_valid", bus.pu_dout_valid, 0);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_sat_cnt", bus.sat_cnt, 0);

        // LUT[i] = i, junk in unused upper address/data bits
        bus.ram_we = 1; bus.ram_mem_adr = 6'h02;
        for (int i = 0; i < 256; i++) begin
            bus.ram_reg_adr = {6'h2A, 8'(i)};
            bus.ram_din     = {13'h1ABC, 8'(i)};
            step();
        end
        // write to another memory select must not land in the LUT
        bus.ram_mem_adr = 6'h03; bus.ram_reg_adr = 14'h0082; bus.ram_din = 21'h55;
        step();
        bus.ram_we = 0;

        // SIG2, x=2 -> LUT[130]
        bus.mode = 3'b011; bus.din = 26'h200; bus.enq = 1; step();
        bus.enq = 0; step(); step();
        check("sig2_lat_count0", bus.count, 0);
        step();
        check("sig2_count1", bus.count, 1);
        bus.deq = 1; step();
        check("sig2_dout", bus.dout, 8'h82);
        check("sig2_valid", bus.dout_valid, 1);
        check("sig2_count_pop", bus.count, 0);
        bus.deq = 0; step();
        check("sig2_valid_hold", bus.dout_valid, 1);
        bus.dout_ack = 1; step();
        check("sig2_ack_valid", bus.dout_valid, 0);
        check("sig2_ack_dout_hold", bus.dout, 8'h82);
        bus.dout_ack = 0;

        // SIG1, x=4 -> pu_dout
        bus.mode = 3'b010; bus.din = 26'h400; bus.enq = 1; step();
        bus.enq = 0; step(); step();
        check("sig1_early_valid", bus.pu_dout_valid, 0);
        step();
        check("sig1_valid", bus.pu_dout_valid, 1);
        check("sig1_pu_dout", bus.pu_dout, 8'h84);
        check("sig1_count", bus.count, 0);
        step();
        check("sig1_strobe_end", bus.pu_dout_valid, 0);

        // SIG2 negative saturating -> LUT[0]
        bus.mode = 3'b011; bus.din = 26'h3FF0000; bus.enq = 1; step();
        bus.enq = 0; step(); step(); step();
        bus.deq = 1; step();
        bus.deq = 0;
        check("sat_dout", bus.dout, 8'h00);
        check("sat_valid", bus.dout_valid, 1);
        check("sat_cnt1", bus.sat_cnt, SAT_EN ? 1 : 0);
        bus.dout_ack = 1; step();
        bus.dout_ack = 0;

        // RELU: -2 -> 0, 5 -> 5, 256 -> FF (saturated)
        bus.mode = 3'b100; bus.enq = 1;
        bus.din = 26'h3FFFE00; step();
        bus.din = 26'h0000500; step();
        bus.din = 26'h0010000; step();
        bus.enq = 0; step(); step(); step();
        check("relu_count", bus.count, 3);
        bus.deq = 1; bus.dout_ack = 1;
        step(); check("relu_d0", bus.dout, 8'h00); check("relu_v0", bus.dout_valid, 1);
        step(); check("relu_d1", bus.dout, 8'h05); check("relu_v1", bus.dout_valid, 1);
        step(); check("relu_d2", bus.dout, 8'hFF); check("relu_v2", bus.dout_valid, 1);
        step(); check("relu_drained", bus.dout_valid, 0);
        bus.deq = 0; bus.dout_ack = 0;
        check("relu_sat_cnt", bus.sat_cnt, SAT_EN ? 2 : 0);

        // fill: 20 enq, only 16 accepted
        bus.mode = 3'b011; bus.enq = 1;
        for (int i = 0; i < 20; i++) begin
            bus.din = 26'(i << 8);
            step();
            if (i == 14) check("fill_not_full", bus.full, 0);
            if (i == 15) check("fill_full", bus.full, 1);
        end
        bus.enq = 0; step(); step(); step();
        check("fill_count16", bus.count, 16);
        check("fill_full_hold", bus.full, 1);
        bus.deq = 1; bus.dout_ack = 1;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("drain_d%0d", k), bus.dout, 32'h80 + 32'(k));
            check($sformatf("drain_v%0d", k), bus.dout_valid, 1);
        end
        step();
        check("drain_end_valid", bus.dout_valid, 0);
        check("drain_end_count", bus.count, 0);
        check("drain_end_full", bus.full, 0);
        bus.deq = 0; bus.dout_ack = 0;

        // reset with queued words, one in dout and two in flight
        bus.mode = 3'b011; bus.enq = 1;
        for (int k = 0; k < 5; k++) begin
            bus.din = 26'((32 + k) << 8);
            step();
        end
        bus.enq = 0; step(); step(); step();
        check("pre_rst_count", bus.count, 5);
        bus.deq = 1; step(); bus.deq = 0;
        check("pre_rst_dout", bus.dout, 8'hA0);
        bus.enq = 1;
        bus.din = 26'h3000; step();
        bus.din = 26'h3100; step();
        bus.enq = 0; RST = 1; step(); RST = 0;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_valid", bus.dout_valid, 0);
        check("mid_rst_dout", bus.dout, 0);
        check("mid_rst_full", bus.full, 0);
        check("mid_rst_sat", bus.sat_cnt, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_no_stale", bus.count, 0);
        end
        bus.mode = 3'b010; bus.din = 26'h200; bus.enq = 1; step();
        bus.enq = 0; step(); step(); step();
        check("post_rst_pu_valid", bus.pu_dout_valid, 1);
        check("post_rst_lut_kept", bus.pu_dout, 8'h82);
        bus.mode = 3'b011; bus.din = 26'h500; bus.enq = 1; step();
        bus.enq = 0; step(); step(); step();
        check("post_rst_count1", bus.count, 1);
        bus.deq = 1; step(); bus.deq = 0;
        check("post_rst_dout", bus.dout, 8'h85);
        check("post_rst_valid", bus.dout_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
